// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver:
// one-hot state encoding, parity modes and legal parameter ranges.
package uart_pkg;

   typedef enum logic [6:0] {
      S_IDLE      = 7'b0000001,
      S_START     = 7'b0000010,
      S_DATA      = 7'b0000100,
      S_PARITY    = 7'b0001000,
      S_STOP      = 7'b0010000,
      S_DONE      = 7'b0100000,
      S_WAIT_HIGH = 7'b1000000
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   localparam int TPB_MIN       = 8;
   localparam int DATA_BITS_MIN = 5;
   localparam int DATA_BITS_MAX = 9;
   localparam int STOP_BITS_MIN = 1;
   localparam int STOP_BITS_MAX = 2;

   function automatic bit cfg_ok(input int tpb, input int tpb_size,
                                 input int dbits, input int par,
                                 input int sbits);
      return (tpb >= TPB_MIN)
          && ((2 ** tpb_size) > tpb)
          && (dbits >= DATA_BITS_MIN) && (dbits <= DATA_BITS_MAX)
          && (par >= PAR_NONE) && (par <= PAR_EVEN)
          && (sbits >= STOP_BITS_MIN) && (sbits <= STOP_BITS_MAX);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser, falling-edge detect and
// 3-sample majority vote around the middle of each bit.
module uart_rx_sampler #(
   parameter int TICKS_PER_BIT      = 32,
   parameter int TICKS_PER_BIT_SIZE = 6
) (
   input  logic                          i_clk,
   input  logic                          reset,
   input  logic                          din,
   input  logic [TICKS_PER_BIT_SIZE-1:0] tick,
   output logic                          rx,
   output logic                          fall,
   output logic                          vote
);

   localparam int W   = TICKS_PER_BIT_SIZE;
   localparam int MID = (TICKS_PER_BIT - 1) / 2;
   localparam logic [W-1:0] T_A = W'(MID - 1);
   localparam logic [W-1:0] T_B = W'(MID);

   logic [1:0] sync_q;
   logic       prev_q;
   logic       smp_a;
   logic       smp_b;

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
         smp_a  <= 1'b1;
         smp_b  <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], din};
         prev_q <= sync_q[1];
         if (tick == T_A) smp_a <= sync_q[1];
         if (tick == T_B) smp_b <= sync_q[1];
      end
   end

   assign rx   = sync_q[1];
   assign fall = prev_q & ~sync_q[1];
   // third sample is the live line at MID+1
   assign vote = (smp_a & smp_b) | (smp_a & rx) | (smp_b & rx);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start/data/parity/stop framing,
// status flags latched once per frame, break detection.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int TICKS_PER_BIT      = 32,
   parameter int TICKS_PER_BIT_SIZE = 6,
   parameter int DATA_BITS          = 8,
   parameter int PARITY             = 0,
   parameter int STOP_BITS          = 1
) (
   input  logic                 i_clk,
   input  logic                 reset,
   input  logic                 i_enable,
   input  logic                 i_din_priortobuffer,
   output logic [DATA_BITS-1:0] o_rxdata,
   output logic                 o_recvdata,
   output logic                 o_busy,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_break
);

   if (!cfg_ok(TICKS_PER_BIT, TICKS_PER_BIT_SIZE, DATA_BITS,
               PARITY, STOP_BITS)) begin : g_bad_cfg
      $error("uart_rx_cfg: illegal parameter set");
   end

   localparam int W   = TICKS_PER_BIT_SIZE;
   localparam int MID = (TICKS_PER_BIT - 1) / 2;
   localparam logic [W-1:0] T_SMP  = W'(MID + 1);
   localparam logic [W-1:0] T_LAST = W'(TICKS_PER_BIT - 1);
   localparam logic [3:0]   DB_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]   SB_LAST = 4'(STOP_BITS - 1);

   rx_state_t state, state_n;

   logic [W-1:0]         cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] data_q;
   logic                 perr_q;
   logic                 ferr_q;
   logic                 stop0_q;
   logic                 parbit_q;

   logic rx;
   logic fall;
   logic vote;
   logic smp;
   logic exp_par;
   logic first_stop;
   logic brk;

   uart_rx_sampler #(
      .TICKS_PER_BIT      (TICKS_PER_BIT),
      .TICKS_PER_BIT_SIZE (TICKS_PER_BIT_SIZE)
   ) u_sampler (
      .i_clk (i_clk),
      .reset (reset),
      .din   (i_din_priortobuffer),
      .tick  (cnt),
      .rx    (rx),
      .fall  (fall),
      .vote  (vote)
   );

   assign smp        = (cnt == T_SMP);
   assign exp_par    = (PARITY == PAR_EVEN) ? ^data_q : ~^data_q;
   assign first_stop = (bit_cnt == 4'd0) ? vote : stop0_q;
   assign brk        = (data_q == '0) & ~parbit_q & ~first_stop;

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:
            if (fall && i_enable) state_n = S_START;
         S_START:
            if (smp) state_n = vote ? S_IDLE : S_DATA;
         S_DATA:
            if (smp && bit_cnt == DB_LAST)
               state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
         S_PARITY:
            if (smp) state_n = S_STOP;
         S_STOP:
            if (smp && bit_cnt == SB_LAST) state_n = S_DONE;
         S_DONE:
            state_n = rx ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH:
            if (rx) state_n = S_IDLE;
         default:
            state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         bit_cnt  <= '0;
         data_q   <= '0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         stop0_q  <= 1'b1;
         parbit_q <= 1'b0;
      end else begin
         if (state == S_IDLE || state_n == S_IDLE) cnt <= '0;
         else if (cnt == T_LAST)                   cnt <= '0;
         else                                      cnt <= cnt + 1'b1;

         if (state_n != state)
            bit_cnt <= '0;
         else if (smp && (state == S_DATA || state == S_STOP))
            bit_cnt <= bit_cnt + 1'b1;

         if (state == S_IDLE && state_n == S_START) begin
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            stop0_q  <= 1'b1;
            parbit_q <= 1'b0;
         end

         if (state == S_DATA && smp)
            data_q <= {vote, data_q[DATA_BITS-1:1]};

         if (state == S_PARITY && smp) begin
            parbit_q <= vote;
            perr_q   <= vote ^ exp_par;
         end

         if (state == S_STOP && smp) begin
            if (!vote) ferr_q <= 1'b1;
            if (bit_cnt == 4'd0) stop0_q <= vote;
         end
      end
   end

   // status is loaded on the last stop sample so it is valid during DONE
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         o_rxdata     <= '0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_break      <= 1'b0;
      end else if (state == S_STOP && smp && bit_cnt == SB_LAST) begin
         o_rxdata     <= data_q;
         o_parity_err <= perr_q;
         o_frame_err  <= ferr_q | ~vote | brk;
         o_break      <= brk;
      end
   end

   assign o_recvdata = (state == S_DONE);
   assign o_busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8E1 instance and a 7N2
// instance share clock, reset and enable.
module tb_uart_rx_cfg;

   localparam int TPB = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       br;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic en = 1'b1;
   logic din8 = 1'b1;
   logic din7 = 1'b1;

   logic [7:0] rxd8;
   logic       rd8, busy8, pe8, fe8, br8;
   logic [6:0] rxd7;
   logic       rd7, busy7, pe7, fe7, br7;

   exp_t q8[$];
   exp_t q7[$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_rx_cfg #(
      .TICKS_PER_BIT(TPB), .TICKS_PER_BIT_SIZE(5),
      .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
   ) dut (
      .i_clk(clk), .reset(reset), .i_enable(en),
      .i_din_priortobuffer(din8),
      .o_rxdata(rxd8), .o_recvdata(rd8), .o_busy(busy8),
      .o_parity_err(pe8), .o_frame_err(fe8), .o_break(br8)
   );

   uart_rx_cfg #(
      .TICKS_PER_BIT(TPB), .TICKS_PER_BIT_SIZE(5),
      .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)
   ) dut7 (
      .i_clk(clk), .reset(reset), .i_enable(en),
      .i_din_priortobuffer(din7),
      .o_rxdata(rxd7), .o_recvdata(rd7), .o_busy(busy7),
      .o_parity_err(pe7), .o_frame_err(fe7), .o_break(br7)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rd8) begin
         if (q8.size() == 0) chk("spurious8", rd8, 0);
         else begin
            e = q8.pop_front();
            chk("rxdata8", rxd8, e.d);
            chk("perr8", pe8, e.pe);
            chk("ferr8", fe8, e.fe);
            chk("brk8", br8, e.br);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rd7) begin
         if (q7.size() == 0) chk("spurious7", rd7, 0);
         else begin
            e = q7.pop_front();
            chk("rxdata7", {1'b0, rxd7}, e.d);
            chk("perr7", pe7, e.pe);
            chk("ferr7", fe7, e.fe);
            chk("brk7", br7, e.br);
         end
      end
   end

   task automatic shift_out(input logic [11:0] bits, input int n,
                            input bit sel7);
      for (int i = 0; i < n; i++) begin
         if (sel7) din7 = bits[i];
         else      din8 = bits[i];
         repeat (TPB) @(posedge clk);
         #1;
      end
      din7 = 1'b1;
      din8 = 1'b1;
      repeat (2 * TPB) @(posedge clk);
      #1;
   endtask

   task automatic send8(input logic [7:0] d, input logic p,
                        input bit expect_it);
      exp_t e;
      e.d  = d;
      e.pe = (p != ^d);
      e.fe = 1'b0;
      e.br = 1'b0;
      if (expect_it) q8.push_back(e);
      shift_out({2'b11, p, d, 1'b0}, 11, 1'b0);
   endtask

   task automatic send7(input logic [6:0] d, input logic st2);
      exp_t e;
      e.d  = {1'b0, d};
      e.pe = 1'b0;
      e.fe = ~st2;
      e.br = 1'b0;
      q7.push_back(e);
      shift_out({2'b11, st2, 1'b1, d, 1'b0}, 10, 1'b1);
   endtask

   initial begin
      exp_t e;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_busy", busy8, 0);
      chk("rst_rd", rd8, 0);
      chk("rst_rxdata", rxd8, 0);
      chk("rst_flags", {pe8, fe8, br8}, 0);
      chk("rst_rxdata7", rxd7, 0);
      reset = 1'b1;
      repeat (3 * TPB) @(posedge clk);
      #1;

      send8(8'hA5, 1'b0, 1);
      send8(8'h3C, 1'b1, 1);
      send8(8'h00, 1'b0, 1);
      send8(8'hFF, 1'b0, 1);
      send8(8'h96, 1'b1, 1);

      // short low glitch
      din8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      din8 = 1'b1;
      chk("glitch_busy_hi", busy8, 1);
      repeat (TPB) @(posedge clk);
      #1;
      chk("glitch_busy_lo", busy8, 0);
      repeat (2 * TPB) @(posedge clk);
      #1;

      // break: 12 bit times low
      e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b1; e.br = 1'b1;
      q8.push_back(e);
      din8 = 1'b0;
      repeat (12 * TPB) @(posedge clk);
      #1;
      chk("break_wait_busy", busy8, 1);
      chk("break_seen", q8.size(), 0);
      din8 = 1'b1;
      repeat (4 * TPB) @(posedge clk);
      #1;
      chk("break_idle", busy8, 0);

      send7(7'h2A, 1'b1);
      send7(7'h55, 1'b0);

      // disabled: frame ignored
      en = 1'b0;
      send8(8'h81, 1'b0, 0);
      chk("dis_busy", busy8, 0);
      en = 1'b1;

      // enable dropped mid-frame: frame still completes
      fork
         send8(8'h5A, 1'b0, 1);
         begin
            repeat (2 * TPB) @(posedge clk);
            #1;
            en = 1'b0;
         end
      join
      en = 1'b1;

      // reset during bit 4 of 0xFF
      din8 = 1'b0;
      repeat (TPB) @(posedge clk);
      #1;
      din8 = 1'b1;
      repeat (4 * TPB + TPB / 2) @(posedge clk);
      #1;
      chk("abort_busy_pre", busy8, 1);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_busy_rst", busy8, 0);
      chk("abort_rxdata_rst", rxd8, 0);
      reset = 1'b1;
      repeat (3 * TPB) @(posedge clk);
      #1;
      send8(8'h12, 1'b0, 1);

      chk("q8_drained", q8.size(), 0);
      chk("q7_drained", q7.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
